// File: rtl/rvvi_stream_ctrl.sv
// rtl/rvvi_stream_ctrl.sv - RVVI trace record FIFO and 32-bit packetiser (optional RVVI_STREAM_COMPRESS_EN trims unused CSR slots)
module rvvi_stream_ctrl #(
   parameter int XLEN     = 64,
   parameter int MAX_CSRS = 3,
   parameter int DEPTH    = 2,
   localparam int RW      = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
   localparam int BASEB   = (72 + 5*XLEN)/8,
   localparam int CSRB    = (XLEN + 16)/8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid,
   input  logic [RW-1:0] rvvi,
   input  logic [11:0]   CSRCount,
   output logic [31:0]   TxData,
   output logic          TxValid,
   output logic          TxLast,
   input  logic          TxReady,
   output logic          RvviStall,
   output logic [15:0]   DropCount
);
   localparam int EW = RW + 12;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH-1);
   localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_BODY = 2'd2;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic [1:0]    state;
   logic [RW-1:0] cur_rec;
   logic [15:0]   len, seq, beat, drops, nbeats, next_len;
   logic          stall;

   logic [11:0]   csr_in;
   logic          full, hs, last_beat, pop, wr, next_avail;
   logic [EW-1:0] next_entry;
   logic [31:0]   body_word;

   always_comb begin
      csr_in    = (CSRCount > 12'(MAX_CSRS)) ? 12'(MAX_CSRS) : CSRCount;
      full      = (count == FULL_CNT);
      hs        = TxValid & TxReady;
      nbeats    = (len + 16'd3) >> 2;
      last_beat = (beat == nbeats - 16'd1);
      pop       = (state == S_BODY) && hs && last_beat;
      wr        = valid && (!full || pop);
      // a write landing with the final pop still counts as "another entry" so packets stay back-to-back
      next_avail = (count > ONE_CNT) || wr;
      if (state == S_IDLE)
         next_entry = mem[rd_ptr];
      else if (count > ONE_CNT)
         next_entry = mem[rd_ptr + AW'(1)];
      else
         next_entry = {csr_in, rvvi};
      count_nxt = count;
      if (wr && !pop)
         count_nxt = count + ONE_CNT;
      else if (pop && !wr)
         count_nxt = count - ONE_CNT;
   end

`ifdef RVVI_STREAM_COMPRESS_EN
   assign next_len = 16'(BASEB) + 16'(CSRB) * {4'd0, next_entry[EW-1 -: 12]};
`else
   logic unused_csr;
   assign unused_csr = ^next_entry[EW-1 -: 12];
   assign next_len   = 16'(RW/8);
`endif

   always_comb begin
      body_word = 32'd0;
      for (int j = 0; j < 4; j++) begin
         if (int'(beat)*4 + j < int'(len))
            body_word[8*j +: 8] = cur_rec[8*(int'(beat)*4 + j) +: 8];
      end
   end

   assign TxValid   = (state == S_HDR) || (state == S_BODY);
   assign TxLast    = (state == S_BODY) && last_beat;
   assign TxData    = (state == S_HDR)  ? {seq, len} :
                      (state == S_BODY) ? body_word  : 32'd0;
   assign RvviStall = stall;
   assign DropCount = drops;

   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= {csr_in, rvvi};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         seq     <= 16'd0;
         drops   <= 16'd0;
         stall   <= 1'b0;
         beat    <= 16'd0;
         len     <= 16'd0;
         cur_rec <= '0;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         stall <= (count_nxt >= STALL_CNT);
         if (valid && !wr && drops != 16'hFFFF)
            drops <= drops + 16'd1;
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  cur_rec <= next_entry[RW-1:0];
                  len     <= next_len;
                  state   <= S_HDR;
               end
            end
            S_HDR: begin
               if (hs) begin
                  seq   <= seq + 16'd1;
                  beat  <= 16'd0;
                  state <= S_BODY;
               end
            end
            S_BODY: begin
               if (hs) begin
                  if (last_beat) begin
                     if (next_avail) begin
                        cur_rec <= next_entry[RW-1:0];
                        len     <= next_len;
                        state   <= S_HDR;
                     end else begin
                        state <= S_IDLE;
                     end
                  end else begin
                     beat <= beat + 16'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rvvi_stream_ctrl.sv
// tb/tb_rvvi_stream_ctrl.sv - directed table-driven bench for rvvi_stream_ctrl (default parameters)
module tb_rvvi_stream_ctrl;
   localparam int RW = 632;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid;
   logic [RW-1:0] rvvi;
   logic [11:0]   CSRCount;
   logic [31:0]   TxData;
   logic          TxValid;
   logic          TxLast;
   logic          TxReady;
   logic          RvviStall;
   logic [15:0]   DropCount;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [15:0]   exp_seq = 16'd0;

   typedef struct {
      logic [11:0] csr;
      int          len;
      int          beats;
   } vec_t;
   vec_t vt [5];

   rvvi_stream_ctrl dut (
      .clk(clk), .reset(reset), .valid(valid), .rvvi(rvvi), .CSRCount(CSRCount),
      .TxData(TxData), .TxValid(TxValid), .TxLast(TxLast), .TxReady(TxReady),
      .RvviStall(RvviStall), .DropCount(DropCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] make_rec(input int k);
      logic [RW-1:0] r;
      for (int i = 0; i < RW/8; i++)
         r[8*i +: 8] = 8'(i*3 + k*17 + 1);
      return r;
   endfunction

   function automatic logic [31:0] exp_beat(input logic [RW-1:0] r, input int len, input int b);
      logic [31:0] w;
      w = 32'd0;
      for (int j = 0; j < 4; j++)
         if (4*b + j < len) w[8*j +: 8] = r[8*(4*b + j) +: 8];
      return w;
   endfunction

   function automatic int exp_len(input int c);
`ifdef RVVI_STREAM_COMPRESS_EN
      return 49 + 10*((c > 3) ? 3 : c);
`else
      return 79;
`endif
   endfunction

   task automatic push(input logic [RW-1:0] r, input logic [11:0] c);
      valid = 1'b1; rvvi = r; CSRCount = c;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic recv(input logic [RW-1:0] r, input int len, input int abort_beat,
                       input bit push_last, input logic [RW-1:0] pr, input logic [11:0] pc);
      int t;
      int beats;
      beats = (len + 3) / 4;
      t = 0;
      while (!TxValid && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!TxValid) begin
         chk("hdr_timeout", 32'd0, 32'd1);
         return;
      end
      chk("hdr_data", TxData, {exp_seq, 16'(len)});
      chk("hdr_last", 32'(TxLast), 32'd0);
      exp_seq++;
      @(posedge clk); #1;
      for (int b = 0; b < beats; b++) begin
         chk("body_valid", 32'(TxValid), 32'd1);
         chk("body_data", TxData, exp_beat(r, len, b));
         chk("body_last", 32'(TxLast), 32'(b == beats-1));
         if (b == abort_beat) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            exp_seq = 16'd0;
            return;
         end
         if (push_last && b == beats-1) begin
            valid = 1'b1; rvvi = pr; CSRCount = pc;
         end
         @(posedge clk); #1;
         valid = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef RVVI_STREAM_COMPRESS_EN
      vt[0] = '{12'd0, 32'h31, 13};
      vt[1] = '{12'd1, 59, 15};
      vt[2] = '{12'd2, 32'h45, 18};
      vt[3] = '{12'd3, 79, 20};
      vt[4] = '{12'd7, 79, 20};
`else
      vt[0] = '{12'd0, 32'h4F, 20};
      vt[1] = '{12'd1, 32'h4F, 20};
      vt[2] = '{12'd2, 32'h4F, 20};
      vt[3] = '{12'd3, 32'h4F, 20};
      vt[4] = '{12'd7, 32'h4F, 20};
`endif
      reset = 1'b1; valid = 1'b0; rvvi = '0; CSRCount = 12'd0; TxReady = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txvalid", 32'(TxValid), 32'd0);
      chk("rst_txlast", 32'(TxLast), 32'd0);
      chk("rst_txdata", TxData, 32'd0);
      chk("rst_stall", 32'(RvviStall), 32'd0);
      chk("rst_drops", 32'(DropCount), 32'd0);
      reset = 1'b0;

      TxReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("vec_beats", 32'((vt[i].len + 3) / 4), 32'(vt[i].beats));
         push(make_rec(i), vt[i].csr);
         recv(make_rec(i), vt[i].len, -1, 1'b0, '0, 12'd0);
         chk("vec_idle_after", 32'(TxValid), 32'd0);
      end

      TxReady = 1'b0;
      valid = 1'b1; rvvi = make_rec(10); CSRCount = 12'd1;
      @(posedge clk); #1;
      chk("stall_after_first", 32'(RvviStall), 32'd1);
      rvvi = make_rec(11); CSRCount = 12'd0;
      @(posedge clk); #1;
      rvvi = make_rec(12); CSRCount = 12'd2;
      @(posedge clk); #1;
      valid = 1'b0;
      chk("drop_count_one", 32'(DropCount), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("hold_valid", 32'(TxValid), 32'd1);
         chk("hold_data", TxData, {exp_seq, 16'(exp_len(1))});
         chk("hold_last", 32'(TxLast), 32'd0);
         @(posedge clk); #1;
      end
      TxReady = 1'b1;
      recv(make_rec(10), exp_len(1), -1, 1'b0, '0, 12'd0);
      chk("b2b_valid", 32'(TxValid), 32'd1);
      recv(make_rec(11), exp_len(0), -1, 1'b0, '0, 12'd0);
      chk("drain_idle", 32'(TxValid), 32'd0);

      TxReady = 1'b0;
      push(make_rec(20), 12'd2);
      push(make_rec(21), 12'd3);
      chk("full_stall", 32'(RvviStall), 32'd1);
      TxReady = 1'b1;
      recv(make_rec(20), exp_len(2), -1, 1'b1, make_rec(22), 12'd0);
      chk("coinc_no_drop", 32'(DropCount), 32'd1);
      chk("coinc_next_hdr", 32'(TxValid), 32'd1);
      chk("coinc_stall", 32'(RvviStall), 32'd1);
      recv(make_rec(21), exp_len(3), -1, 1'b0, '0, 12'd0);
      chk("coinc_b2b", 32'(TxValid), 32'd1);
      recv(make_rec(22), exp_len(0), -1, 1'b0, '0, 12'd0);
      chk("coinc_idle", 32'(TxValid), 32'd0);

      push(make_rec(30), 12'd1);
      recv(make_rec(30), exp_len(1), 5, 1'b0, '0, 12'd0);
      chk("abort_txvalid", 32'(TxValid), 32'd0);
      chk("abort_txlast", 32'(TxLast), 32'd0);
      chk("abort_txdata", TxData, 32'd0);
      chk("abort_stall", 32'(RvviStall), 32'd0);
      chk("abort_drops", 32'(DropCount), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_fifo_empty", 32'(TxValid), 32'd0);
      push(make_rec(31), 12'd2);
      recv(make_rec(31), exp_len(2), -1, 1'b0, '0, 12'd0);
      chk("post_abort_idle", 32'(TxValid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rvvi_stream_ctrl.md
RVVI_STREAM_CTRL -- requirements
Module: rvvi_stream_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: register width of the traced core.
REQ-002 SHALL have parameter MAX_CSRS, default 3: CSR slots per record.
REQ-003 SHALL have parameter DEPTH, default 2: record FIFO entries, power of two, at least 2.
REQ-004 SHALL define derived record width RW = 72+5*XLEN+MAX_CSRS*(XLEN+16), which is a multiple of 8; BASEB = (72+5*XLEN)/8; CSRB = (XLEN+16)/8.
REQ-005 SHALL have port clk, input, 1: clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port valid, input, 1: record present this cycle.
REQ-008 SHALL have port rvvi, input, RW: trace record, with the Required/Registers part at the LSBs and CSR slots above it.
REQ-009 SHALL have port CSRCount, input, 12: valid CSR slots in the record, 0..MAX_CSRS.
REQ-010 SHALL have port TxData, output, 32: outbound beat.
REQ-011 SHALL have port TxValid, output, 1: beat valid.
REQ-012 SHALL have port TxLast, output, 1: final beat of a packet.
REQ-013 SHALL have port TxReady, input, 1: sink accepts the beat.
REQ-014 SHALL have port RvviStall, output, 1: request for the core to hold the pipeline.
REQ-015 SHALL have port DropCount, output, 16: records lost to overflow.

Function
REQ-016 SHALL write {CSRCount, rvvi} into the FIFO on a cycle with valid=1 and FIFO not full, including when the FIFO is empty (no bypass).
REQ-017 SHALL drop a record that arrives when the FIFO is full, increment DropCount, and saturate DropCount at 0xFFFF.
REQ-018 SHALL drive RvviStall=1 when occupancy >= DEPTH-1, registered, with the value updated in the same cycle as the write or read that changes occupancy.
REQ-019 SHALL sequence packets with an FSM of states IDLE, HDR and BODY.
REQ-020 SHALL go from IDLE to HDR when the FIFO is non-empty, latching the head entry and its byte length LEN.
REQ-021 SHALL send a header beat in HDR: TxData = {Seq[15:0], LEN[15:0]}.
REQ-022 SHALL go from HDR to BODY on the TxValid&TxReady handshake and then increment Seq; Seq wraps from 0xFFFF to 0.
REQ-023 SHALL send ceil(LEN/4) beats in BODY, taking the record bytes LSB first, 4 bytes per beat, with bytes at positions >= LEN driven to zero.
REQ-024 SHALL assert TxLast only on the final BODY beat.
REQ-025 SHALL, on the handshake of the final BODY beat, pop the FIFO and go to HDR if another entry is present, otherwise to IDLE, with no idle cycle between packets.
REQ-026 SHALL hold TxData and TxLast stable while TxValid=1 and TxReady=0; TxValid SHALL NOT drop before its handshake.
REQ-027 SHALL allow a FIFO write and a pop in the same cycle, with occupancy unchanged and no drop, even when the FIFO is full.
REQ-028 SHALL clamp a CSRCount greater than MAX_CSRS to MAX_CSRS.
REQ-029 SHALL assert TxValid=0 in IDLE.

Reset
REQ-030 SHALL, on reset, set the FSM to IDLE, empty the FIFO, and zero Seq and DropCount.
REQ-031 SHALL drive these output values during and after reset: TxValid=0, TxLast=0, TxData=0, RvviStall=0, DropCount=0.
REQ-032 SHALL abandon a packet in progress when reset is asserted mid-packet, without emitting TxLast, and SHALL restart with Seq=0.

Configuration
REQ-033 SHALL, when macro RVVI_STREAM_COMPRESS_EN is defined, compute LEN = BASEB + CSRB*CSRCount (after clamping).
REQ-034 SHALL, when RVVI_STREAM_COMPRESS_EN is undefined, use LEN = RW/8 for every packet, send all CSR slots, and ignore CSRCount except for storage.

Verification (XLEN=64, MAX_CSRS=3, DEPTH=2, RW=632, BASEB=49, CSRB=10)
REQ-035 SHALL cover: compress on, one record with CSRCount=0 and TxReady=1 -> header 0x00000031, then 13 body beats; beat 12 holds byte 48 in [7:0] with [31:8]=0 and TxLast=1.
REQ-036 SHALL cover: compress on, CSRCount=2 -> LEN=69 (header low half 0x0045), 18 body beats; the second record carries Seq=1 in header [31:16].
REQ-037 SHALL cover: compress off, CSRCount=1 -> LEN=79 (header 0x0000004F), 20 body beats.
REQ-038 SHALL cover: TxReady=0 held, valid pulsed 3 times -> first two records accepted, third dropped, DropCount=1, RvviStall=1 after the first write; TxData stays stable during the stall.
REQ-039 SHALL cover: reset asserted on body beat 5 -> next cycle TxValid=0, FSM in IDLE, FIFO empty; the following packet has Seq=0.
REQ-040 SHALL cover: FIFO full, final-beat handshake coincident with valid -> no drop, occupancy stays 2, next header is sent on the following cycle.
